// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: byte-side handshake bundle for the uart_rx_frame receiver.
//
// Signals:
//   rx         serial line, idle high (driven by the line side)
//   rdy_clr    acknowledge; clears rdy, frame_err and overrun
//   dout       last received byte
//   rdy        byte available
//   busy       receiver is inside a frame
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte completed while rdy was still set
//
// Modports:
//   master  consumer / line side (drives rx and rdy_clr)
//   slave   the receiver itself
interface uart_rx_frame_if;
   logic       rx;
   logic       rdy_clr;
   logic [7:0] dout;
   logic       rdy;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   modport master (
      output rx, rdy_clr,
      input  dout, rdy, busy, frame_err, overrun
   );

   modport slave (
      input  rx, rdy_clr,
      output dout, rdy, busy, frame_err, overrun
   );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver, LSB first, 16x oversampling, with start-bit
// validation, framing-error and overrun detection.
//
// Parameters:
//   CLK_HZ  input clock frequency in Hz
//   BAUD    line rate; DIV = CLK_HZ/(BAUD*16) clocks per oversample tick (>= 1)
//
// Ports:
//   clk_50m  clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      uart_rx_frame_if.slave (rx, rdy_clr in; dout, rdy, busy, frame_err,
//            overrun out)
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, data and stop bits are a 2-of-3 majority of
//                        samples at oversample counts 13, 14 and 15; otherwise a
//                        single sample at count 15. Frame timing is the same.
module uart_rx_frame #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input logic            clk_50m,
   input logic            rst_n,
   uart_rx_frame_if.slave bus
);

   localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
   localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_t;

   // Input synchronizer; both flops idle high so reset never looks like a start bit.
   logic rx_meta, rx_s;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // Free-running oversample tick generator.
   logic [TW-1:0] tick_cnt_q;
   logic          tick;

   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TW'(1);
      end
   end

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] dout_q, dout_d;
   logic       rdy_q, rdy_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;
   logic       bit_val;

`ifdef UART_RX_MAJORITY_EN
   // Early samples of the current bit: [0] at count 13, [1] at count 14.
   logic [1:0] maj_q, maj_d;

   always_comb begin
      maj_d = maj_q;
      if (tick && (state_q == StData || state_q == StStop)) begin
         if (cnt_q == 4'd13) maj_d[0] = rx_s;
         if (cnt_q == 4'd14) maj_d[1] = rx_s;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         maj_q <= '0;
      end else begin
         maj_q <= maj_d;
      end
   end

   assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
   assign bit_val = rx_s;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      dout_d      = dout_q;
      rdy_d       = rdy_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;

      // Acknowledge first; a frame completing on the same edge overrides below.
      if (bus.rdy_clr) begin
         rdy_d       = 1'b0;
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end

      if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  cnt_d   = 4'd0;
                  state_d = StStart;
               end
            end
            StStart: begin
               if (cnt_q == 4'd7) begin
                  if (rx_s) begin
                     state_d = StIdle;
                  end else begin
                     cnt_d     = 4'd0;
                     bit_idx_d = 3'd0;
                     state_d   = StData;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StData: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  shreg_d[bit_idx_q] = bit_val;
                  if (bit_idx_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
            StStop: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  if (bit_val) begin
                     dout_d = shreg_q;
                     rdy_d  = 1'b1;
                     if (rdy_q && !bus.rdy_clr) overrun_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = StWaitHigh;
                  end
               end
            end
            StWaitHigh: begin
               // Hold here through a break so it yields a single frame_err.
               if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         dout_q      <= '0;
         rdy_q       <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         dout_q      <= dout_d;
         rdy_q       <= rdy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.rdy       = rdy_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at CLK_HZ=16, BAUD=1 (one tick per clock, 16 clocks per
// bit). Line stimulus is clock-exact; expected outputs come from a small
// frame-level model of the byte handshake (rdy/dout/frame_err/overrun).
module tb_uart_rx_frame;

   localparam int unsigned CLK_HZ = 16;
   localparam int unsigned BAUD   = 1;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;

   always #5 clk_50m = ~clk_50m;

   uart_rx_frame_if bus ();

   uart_rx_frame #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) dut (
      .clk_50m(clk_50m),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int passes = 0;

   // Reference model of the byte-side outputs.
   logic [7:0] m_dout = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_fe   = 1'b0;
   logic       m_ovr  = 1'b0;

   task automatic tick1();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic idle(input int n);
      bus.rx      = 1'b1;
      bus.rdy_clr = 1'b0;
      repeat (n) tick1();
   endtask

   task automatic clear();
      bus.rdy_clr = 1'b1;
      tick1();
      bus.rdy_clr = 1'b0;
      m_rdy = 1'b0;
      m_fe  = 1'b0;
      m_ovr = 1'b0;
   endtask

   // Byte a single-sample or majority receiver decodes when one clock of a bit is
   // forced low at oversample count glitch_cnt.
   function automatic logic [7:0] decoded(input logic [7:0] data, input int glitch_bit,
                                          input int glitch_cnt);
      logic [7:0] r;
      r = data;
      if (glitch_bit >= 0 && !MAJ && glitch_cnt == 15) r[glitch_bit] = 1'b0;
      return r;
   endfunction

   // Handshake effect of one completed frame.
   task automatic model_frame(input logic [7:0] b, input logic stop, input logic clr);
      if (stop) begin
         if (m_rdy && !clr) m_ovr = 1'b1;
         if (clr) begin
            m_fe  = 1'b0;
            m_ovr = 1'b0;
         end
         m_rdy  = 1'b1;
         m_dout = b;
      end else begin
         if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
         m_fe = 1'b1;
      end
   endtask

   // Drives one 160-clock frame. glitch_k/clr_k select a clock index (or -1).
   // busy_at/rdy_at report the clock index at which busy rose / rdy rose.
   task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_k,
                             input int clr_k, output int busy_at, output int rdy_at);
      int   b;
      logic v;
      logic prev_rdy;
      busy_at  = -1;
      rdy_at   = -1;
      prev_rdy = bus.rdy;
      for (int k = 0; k < 160; k++) begin
         b = k / 16;
         if (b == 0) v = 1'b0;
         else if (b <= 8) v = data[b-1];
         else v = stop;
         if (k == glitch_k) v = 1'b0;
         bus.rx      = v;
         bus.rdy_clr = (k == clr_k);
         tick1();
         if (busy_at < 0 && bus.busy) busy_at = k + 1;
         if (rdy_at < 0 && bus.rdy && !prev_rdy) rdy_at = k + 1;
         prev_rdy = bus.rdy;
      end
      bus.rdy_clr = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx      = 1'b1;
      bus.rdy_clr = 1'b0;
      rst_n       = 1'b0;
      repeat (3) tick1();
      checks++;
      if ({bus.busy, bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== 12'h000)
         $display("FAIL reset: got busy/rdy/fe/ovr/dout=%b%b%b%b/%h required 0000/00",
                  bus.busy, bus.rdy, bus.frame_err, bus.overrun, bus.dout);
      else passes++;
      rst_n = 1'b1;
      idle(5);
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", bus.busy);
      else passes++;
   endtask

   task automatic test_clean();
      int         busy_at, rdy_at;
      logic [7:0] d;
      send_frame(8'hA5, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'hA5, 1'b1, 1'b0);
      checks++;
      if (busy_at !== 3) $display("FAIL clean_busy_rise: got clk %0d required 3", busy_at);
      else passes++;
      // Detect at clock 3, stop sample 152 ticks later.
      checks++;
      if (rdy_at !== 155) $display("FAIL clean_rdy_time: got clk %0d required 155", rdy_at);
      else passes++;
      checks++;
      if ({bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== {m_rdy, m_fe, m_ovr, m_dout})
         $display("FAIL clean_a5: got rdy/fe/ovr/dout=%b%b%b/%h required %b%b%b/%h",
                  bus.rdy, bus.frame_err, bus.overrun, bus.dout, m_rdy, m_fe, m_ovr, m_dout);
      else passes++;
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL clean_busy_fall: got %b required 0", bus.busy);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         clear();
         d = 8'($urandom);
         send_frame(d, 1'b1, -1, -1, busy_at, rdy_at);
         model_frame(d, 1'b1, 1'b0);
         checks++;
         if ({bus.rdy, bus.overrun, bus.dout} !== {m_rdy, m_ovr, m_dout})
            $display("FAIL clean_rand%0d: got rdy/ovr/dout=%b%b/%h required %b%b/%h", i,
                     bus.rdy, bus.overrun, bus.dout, m_rdy, m_ovr, m_dout);
         else passes++;
      end
   endtask

   task automatic test_false_start();
      int   busy_at, rdy_at;
      logic saw_busy;
      clear();
      saw_busy = 1'b0;
      for (int k = 0; k < 11; k++) begin
         bus.rx = (k < 4) ? 1'b0 : 1'b1;
         tick1();
         if (bus.busy) saw_busy = 1'b1;
      end
      checks++;
      if ({saw_busy, bus.busy, bus.rdy} !== 3'b100)
         $display("FAIL false_start: got saw_busy/busy/rdy=%b%b%b required 100",
                  saw_busy, bus.busy, bus.rdy);
      else passes++;
      idle(10);
      send_frame(8'h3C, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h3C, 1'b1, 1'b0);
      checks++;
      if ({bus.rdy, bus.frame_err, bus.dout} !== {m_rdy, m_fe, m_dout})
         $display("FAIL false_start_3c: got rdy/fe/dout=%b%b/%h required %b%b/%h",
                  bus.rdy, bus.frame_err, bus.dout, m_rdy, m_fe, m_dout);
      else passes++;
   endtask

   task automatic test_frame_err();
      int busy_at, rdy_at;
      int bad;
      clear();
      send_frame(8'h7E, 1'b0, -1, -1, busy_at, rdy_at);
      model_frame(8'h7E, 1'b0, 1'b0);
      checks++;
      if ({bus.frame_err, bus.rdy} !== 2'b10)
         $display("FAIL frame_err_set: got fe/rdy=%b%b required 10", bus.frame_err, bus.rdy);
      else passes++;
      // Break: 40 bit times low; nothing may change and frame_err must not re-pulse.
      bad    = 0;
      bus.rx = 1'b0;
      for (int k = 0; k < 640; k++) begin
         tick1();
         if (bus.rdy !== 1'b0 || bus.dout !== m_dout || bus.frame_err !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL frame_err_break: got %0d bad clocks required 0", bad);
      else passes++;
      idle(20);
      checks++;
      if (bus.busy !== 1'b0)
         $display("FAIL frame_err_release: got busy=%b required 0", bus.busy);
      else passes++;
      send_frame(8'h81, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h81, 1'b1, 1'b0);
      checks++;
      if ({bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== {m_rdy, m_fe, m_ovr, m_dout})
         $display("FAIL frame_err_81: got rdy/fe/ovr/dout=%b%b%b/%h required %b%b%b/%h",
                  bus.rdy, bus.frame_err, bus.overrun, bus.dout, m_rdy, m_fe, m_ovr, m_dout);
      else passes++;
   endtask

   task automatic test_overrun();
      int busy_at, rdy_at;
      clear();
      send_frame(8'h01, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h02, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h02, 1'b1, 1'b0);
      checks++;
      if ({bus.rdy, bus.overrun, bus.dout} !== {m_rdy, m_ovr, m_dout})
         $display("FAIL overrun_set: got rdy/ovr/dout=%b%b/%h required %b%b/%h",
                  bus.rdy, bus.overrun, bus.dout, m_rdy, m_ovr, m_dout);
      else passes++;
      clear();
      checks++;
      if ({bus.rdy, bus.overrun} !== {m_rdy, m_ovr})
         $display("FAIL overrun_clr: got rdy/ovr=%b%b required %b%b",
                  bus.rdy, bus.overrun, m_rdy, m_ovr);
      else passes++;
   endtask

   task automatic test_clr_collision();
      int         busy_at, rdy_at;
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, 1'b0, -1, -1, busy_at, rdy_at);
      model_frame(d, 1'b0, 1'b0);
      idle(4);
      send_frame(8'h01, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h01, 1'b1, 1'b0);
      // rdy_clr seen on the same edge as the stop sample (clock 155).
      send_frame(8'h03, 1'b1, -1, 154, busy_at, rdy_at);
      model_frame(8'h03, 1'b1, 1'b1);
      checks++;
      if ({bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== {m_rdy, m_fe, m_ovr, m_dout})
         $display("FAIL clr_vs_valid: got rdy/fe/ovr/dout=%b%b%b/%h required %b%b%b/%h",
                  bus.rdy, bus.frame_err, bus.overrun, bus.dout, m_rdy, m_fe, m_ovr, m_dout);
      else passes++;
      send_frame(d, 1'b0, -1, 154, busy_at, rdy_at);
      model_frame(d, 1'b0, 1'b1);
      checks++;
      if ({bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== {m_rdy, m_fe, m_ovr, m_dout})
         $display("FAIL clr_vs_ferr: got rdy/fe/ovr/dout=%b%b%b/%h required %b%b%b/%h",
                  bus.rdy, bus.frame_err, bus.overrun, bus.dout, m_rdy, m_fe, m_ovr, m_dout);
      else passes++;
      idle(4);
   endtask

   task automatic test_reset_mid();
      int         busy_at, rdy_at;
      logic [7:0] d;
      clear();
      d = 8'($urandom_range(1, 255));
      send_frame(d, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(d, 1'b1, 1'b0);
      // 0xFF with reset in the middle of data bit 4.
      for (int k = 0; k < 160; k++) begin
         if (k == 88) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if ({bus.busy, bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== 12'h000)
               $display("FAIL reset_mid: got busy/rdy/fe/ovr/dout=%b%b%b%b/%h required 0000/00",
                        bus.busy, bus.rdy, bus.frame_err, bus.overrun, bus.dout);
            else passes++;
         end
         if (k == 96) rst_n = 1'b1;
         bus.rx = (k < 16) ? 1'b0 : 1'b1;
         tick1();
      end
      m_rdy  = 1'b0;
      m_fe   = 1'b0;
      m_ovr  = 1'b0;
      m_dout = 8'h00;
      checks++;
      if ({bus.busy, bus.rdy} !== 2'b00)
         $display("FAIL reset_mid_tail: got busy/rdy=%b%b required 00", bus.busy, bus.rdy);
      else passes++;
      idle(5);
      send_frame(8'h55, 1'b1, -1, -1, busy_at, rdy_at);
      model_frame(8'h55, 1'b1, 1'b0);
      checks++;
      if ({bus.rdy, bus.overrun, bus.dout} !== {m_rdy, m_ovr, m_dout})
         $display("FAIL reset_mid_55: got rdy/ovr/dout=%b%b/%h required %b%b/%h",
                  bus.rdy, bus.overrun, bus.dout, m_rdy, m_ovr, m_dout);
      else passes++;
   endtask

   task automatic test_glitch();
      int         busy_at, rdy_at;
      int         n, c;
      logic [7:0] d, exp;
      clear();
      c   = MAJ ? 14 : 15;
      exp = decoded(8'hFF, 0, c);
      // Clock index k is first seen by the FSM three clocks later.
      send_frame(8'hFF, 1'b1, 9 + c, -1, busy_at, rdy_at);
      checks++;
      if ({bus.rdy, bus.dout} !== {1'b1, exp})
         $display("FAIL glitch_ff: got rdy/dout=%b/%h required 1/%h", bus.rdy, bus.dout, exp);
      else passes++;
      for (int i = 0; i < 6; i++) begin
         clear();
         n    = $urandom_range(0, 7);
         c    = $urandom_range(13, 15);
         d    = 8'($urandom);
         d[n] = 1'b1;
         exp  = decoded(d, n, c);
         send_frame(d, 1'b1, 9 + 16 * n + c, -1, busy_at, rdy_at);
         checks++;
         if (bus.dout !== exp)
            $display("FAIL glitch_rand%0d: bit %0d cnt %0d got dout=%h required %h",
                     i, n, c, bus.dout, exp);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      int         busy_at, rdy_at;
      logic [7:0] d;
      logic       stop, clr;
      clear();
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 3) == 0) clear();
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 2) == 0);
         send_frame(d, stop, -1, clr ? 154 : -1, busy_at, rdy_at);
         model_frame(d, stop, clr);
         checks++;
         if ({bus.rdy, bus.frame_err, bus.overrun, bus.dout} !== {m_rdy, m_fe, m_ovr, m_dout})
            $display("FAIL b2b%0d: got rdy/fe/ovr/dout=%b%b%b/%h required %b%b%b/%h", i,
                     bus.rdy, bus.frame_err, bus.overrun, bus.dout, m_rdy, m_fe, m_ovr, m_dout);
         else passes++;
         if (!stop) idle(4);
      end
   endtask

   initial begin
      bus.rx      = 1'b1;
      bus.rdy_clr = 1'b0;
      test_reset();
      test_clean();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_clr_collision();
      test_reset_mid();
      test_glitch();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
